// File: rtl/time_set_ctrl_pkg.sv
// Shared types, BCD field limits and the BCD increment helper for the time-set front end.
package time_set_pkg;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        E_DAY  = 3'd1,
        E_HOUR = 3'd2,
        E_MIN  = 3'd3,
        E_SEC  = 3'd4
    } state_t;

    localparam logic [7:0] DAY_MIN  = 8'h01;
    localparam logic [7:0] DAY_MAX  = 8'h31;
    localparam logic [7:0] HOUR_MIN = 8'h00;
    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] MS_MIN   = 8'h00;
    localparam logic [7:0] MS_MAX   = 8'h59;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_DAY  = 2'd1;
    localparam logic [1:0] SEL_HOUR = 2'd2;
    localparam logic [1:0] SEL_MIN  = 2'd3;
    localparam logic [1:0] SEL_SEC  = 2'd3;

    // Invalid BCD digits or values outside [lo, hi] snap to lo; byte compares are
    // only meaningful once both nibbles are known to be decimal digits.
    function automatic logic [7:0] bcd_inc(input logic [7:0] val,
                                           input logic [7:0] lo,
                                           input logic [7:0] hi);
        logic [7:0] res;
        if (val[7:4] > 4'd9 || val[3:0] > 4'd9 || val < lo || val > hi) begin
            res = lo;
        end else if (val == hi) begin
            res = lo;
        end else if (val[3:0] == 4'd9) begin
            res = {val[7:4] + 4'd1, 4'd0};
        end else begin
            res = val + 8'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/time_set_ctrl_btn_debounce.sv
// Two-flop synchroniser, consecutive-sample debounce and one-cycle press pulse for a push-button.
module btn_debounce
    import time_set_pkg::*;
#(
    parameter int DEB_MS = 20
) (
    input  logic CLK1K,
    input  logic RST,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam logic [9:0] DEB_LAST = 10'(DEB_MS - 1);

    logic       sync_p0;
    logic       sync_p1;
    logic [9:0] cnt;

    always_ff @(posedge CLK1K) begin
        if (RST) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            press   <= 1'b0;
        end else begin
            // synchroniser stage boundary
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
            press   <= 1'b0;
            // any sample agreeing with the accepted level restarts the run count
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == DEB_LAST) begin
                level <= sync_p1;
                press <= sync_p1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 10'd1;
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven day/hour/min/sec editor that loads the running clock via SW1.
// Optional build macro AUTOREPEAT_EN adds hold-to-repeat on the UP button.
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int DEB_MS   = 20,
    parameter int BLINK_MS = 500,
    parameter int HOLD_MS  = 500,
    parameter int RPT_MS   = 100
) (
    input  logic       CLK1K,
    input  logic       RST,
    input  logic       BTN_MODE,
    input  logic       BTN_UP,
    input  logic [7:0] CUR_SEC,
    input  logic [7:0] CUR_MIN,
    input  logic [7:0] CUR_HOUR,
    input  logic [7:0] CUR_DAY,
    output logic       SW1,
    output logic [7:0] SEC_SET,
    output logic [7:0] MIN_SET,
    output logic [7:0] HOUR_SET,
    output logic [7:0] DAY_SET,
    output logic [1:0] SEL,
    output logic       EDIT_SEC,
    output logic       BLINK
);

    localparam logic [15:0] BLINK_LAST = 16'(BLINK_MS - 1);

    state_t      state_q;
    state_t      state_nxt;
    logic        state_chg;
    logic        mode_press;
    logic        mode_lvl;
    logic        up_press;
    logic        up_lvl;
    logic        rpt_fire;
    logic        inc_req;
    logic [15:0] blink_cnt;
    logic        unused_cfg;

    btn_debounce #(.DEB_MS(DEB_MS)) u_deb_mode (
        .CLK1K (CLK1K),
        .RST   (RST),
        .btn   (BTN_MODE),
        .level (mode_lvl),
        .press (mode_press)
    );

    btn_debounce #(.DEB_MS(DEB_MS)) u_deb_up (
        .CLK1K (CLK1K),
        .RST   (RST),
        .btn   (BTN_UP),
        .level (up_lvl),
        .press (up_press)
    );

    always_ff @(posedge CLK1K) begin
        if (RST) begin
            state_q <= RUN;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        SW1       = 1'b0;
        SEL       = SEL_NONE;
        EDIT_SEC  = 1'b0;
        if (mode_press) begin
            case (state_q)
                RUN:     state_nxt = E_DAY;
                E_DAY:   state_nxt = E_HOUR;
                E_HOUR:  state_nxt = E_MIN;
                E_MIN:   state_nxt = E_SEC;
                default: state_nxt = RUN;
            endcase
        end
        case (state_q)
            E_DAY: begin
                SW1 = 1'b1;
                SEL = SEL_DAY;
            end
            E_HOUR: begin
                SW1 = 1'b1;
                SEL = SEL_HOUR;
            end
            E_MIN: begin
                SW1 = 1'b1;
                SEL = SEL_MIN;
            end
            E_SEC: begin
                SW1      = 1'b1;
                SEL      = SEL_SEC;
                EDIT_SEC = 1'b1;
            end
            default: ;
        endcase
        state_chg = (state_nxt != state_q);
    end

    // MODE has priority: a coincident UP press or repeat tick is dropped
    assign inc_req = (state_q != RUN) && !mode_press && (up_press || rpt_fire);

`ifdef AUTOREPEAT_EN
    localparam logic [15:0] HOLD_LAST  = 16'(HOLD_MS);
    localparam logic [15:0] RPT_RELOAD = 16'(HOLD_MS - RPT_MS + 1);

    logic [15:0] hold_cnt;

    // hold_cnt is 0 in the press cycle, so the first repeat lands HOLD_MS later
    // and the reload spaces later repeats RPT_MS apart
    always_ff @(posedge CLK1K) begin
        if (RST || !up_lvl || state_q == RUN || state_chg) begin
            hold_cnt <= '0;
        end else if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= RPT_RELOAD;
        end else begin
            hold_cnt <= hold_cnt + 16'd1;
        end
    end

    assign rpt_fire   = up_lvl && (state_q != RUN) && (hold_cnt == HOLD_LAST);
    assign unused_cfg = mode_lvl;
`else
    assign rpt_fire   = 1'b0;
    assign unused_cfg = ^{mode_lvl, up_lvl, 16'(HOLD_MS), 16'(RPT_MS)};
`endif

    always_ff @(posedge CLK1K) begin
        if (RST) begin
            SEC_SET  <= MS_MIN;
            MIN_SET  <= MS_MIN;
            HOUR_SET <= HOUR_MIN;
            DAY_SET  <= DAY_MIN;
        end else if (state_q == RUN && mode_press) begin
            SEC_SET  <= CUR_SEC;
            MIN_SET  <= CUR_MIN;
            HOUR_SET <= CUR_HOUR;
            DAY_SET  <= CUR_DAY;
        end else if (inc_req) begin
            case (state_q)
                E_DAY:   DAY_SET  <= bcd_inc(DAY_SET, DAY_MIN, DAY_MAX);
                E_HOUR:  HOUR_SET <= bcd_inc(HOUR_SET, HOUR_MIN, HOUR_MAX);
                E_MIN:   MIN_SET  <= bcd_inc(MIN_SET, MS_MIN, MS_MAX);
                E_SEC:   SEC_SET  <= bcd_inc(SEC_SET, MS_MIN, MS_MAX);
                default: ;
            endcase
        end
    end

    // Restarting the phase on every edit keeps the field visible right after a change
    always_ff @(posedge CLK1K) begin
        if (RST || state_nxt == RUN || state_chg || inc_req) begin
            blink_cnt <= '0;
            BLINK     <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            BLINK     <= ~BLINK;
        end else begin
            blink_cnt <= blink_cnt + 16'd1;
        end
    end

endmodule
